report_offset_collector: RTL and testbench
==========================================

Name: report_offset_collector

Overview:
- Sits directly downstream of an automaton's report STE output (one report bit per automaton).
- Counts consumed symbols and, on each report pulse, tags the report with the index of the symbol that triggered it and the automaton ID.
- Buffers tagged reports in a small FIFO and drains them through a valid/ready stream toward the kernel's report-writer.
- Tracks dropped reports when the buffer overflows.

Parameters:
- OFFSET_W, 32: symbol-offset counter width; offsets wrap modulo 2^OFFSET_W.
- ID_W, 16: automaton ID field width.
- AUTOMATA_ID, 62: constant ID placed in every record.
- DEPTH, 16: FIFO entries; power of two, at least 2.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset (0 = in reset). Assertion clears all state immediately; deassertion is synchronous to clk.
- run, in, 1: the automaton consumed a symbol this cycle. Same run that drives the STEs.
- clear, in, 1: synchronous restart for a new stream. Zeroes counters, FIFO and flags; has priority over all other inputs.
- report, in, 1: registered report output of the automaton's reporting STE.
- m_valid, out, 1: output record available.
- m_ready, in, 1: downstream accepts the record.
- m_data, out, ID_W+OFFSET_W: {AUTOMATA_ID, offset}, with the ID in the MSBs.
- fifo_level, out, log2(DEPTH)+1: current number of entries, 0..DEPTH.
- overflow, out, 1: sticky; a report was dropped.
- drop_count, out, 16: saturating count of dropped reports.

Behaviour:
- Reset values: m_valid=0, m_data=0, fifo_level=0, overflow=0, drop_count=0. Internal sym_count=0, last_idx=0, run_d=0.
- Symbol counting: when run=1, last_idx<=sym_count and sym_count<=sym_count+1 (wraps at 2^OFFSET_W); run_d<=run each cycle.
- Report qualification:
  - The STE output lags its symbol by one cycle.
  - report is accepted only when run_d=1; push record {AUTOMATA_ID, last_idx}.
  - report with run_d=0 is ignored and is not a drop.
- Latency: symbol at index k consumed in cycle t, report high in t+1, record visible on m_valid/m_data in t+2 if the FIFO was empty.
- FIFO:
  - Synchronous, DEPTH entries, first-word stored in a registered output stage.
  - m_valid = (level != 0). m_data = head entry.
  - m_data must stay stable while m_valid=1 and m_ready=0.
  - Pop occurs when m_valid && m_ready.
- Full and simultaneous push/pop:
  - When level==DEPTH and a pop occurs in the same cycle, the push is accepted and level stays DEPTH.
  - When level==DEPTH with no pop, the push is dropped: overflow<=1 and drop_count<=drop_count+1, saturating at 16'hFFFF.
- Empty:
  - m_ready while m_valid=0 has no effect.
  - A push into an empty FIFO has no same-cycle bypass; m_valid rises the next cycle.
- Order: records leave in push order, with no duplication or loss except counted drops.
- Level: fifo_level = level + push_accepted − pop, registered.
- clear:
  - Next cycle sym_count, last_idx, run_d, level, overflow and drop_count are all 0, and m_valid=0.
  - A report or run coincident with clear is discarded.
- Reset mid-operation: asynchronous return to reset values, including mid-handshake. Pending records are lost.

Test Plan:
- Basic tagging: run=1 for 5 cycles (indices 0..4), report pulsed the cycle after index 3 is consumed, m_ready=1 → one record, m_data={16'd62, 32'd3}, 2 cycles after the index-3 symbol.
- Unqualified report: run=0 throughout, report=1 for 3 cycles → m_valid stays 0, drop_count=0.
- Backpressure: m_ready=0, 4 qualified reports at indices 1,2,5,9 → fifo_level=4, m_data holds offset 1 stable. Then m_ready=1 → offsets 1,2,5,9 in order, one per cycle; level returns to 0.
- Overflow: DEPTH=16, m_ready=0, 18 qualified reports → level=16, overflow=1, drop_count=2. Then drain → the first 16 offsets are seen. Also: full FIFO with push and pop in the same cycle → level stays 16, no drop.
- Wrap: OFFSET_W=4, run=1 for 18 symbols, report after index 17 → recorded offset=1.
- clear/reset: with 3 records queued and overflow=1, pulse clear → next cycle m_valid=0, level=0, overflow=0, drop_count=0, and the next symbol is offset 0. Repeat with reset=0 asserted asynchronously mid-cycle → outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/report_offset_collector.sv
// Tags each qualified automaton report with the index of the symbol that triggered it.
// Tagged records go into a small FIFO that drains over a valid/ready stream; reports lost to a full FIFO are counted.
module report_offset_collector #(
  parameter int OFFSET_W    = 32,
  parameter int ID_W        = 16,
  parameter int AUTOMATA_ID = 62,
  parameter int DEPTH       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         clear,
  input  logic                         report,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [ID_W+OFFSET_W-1:0]     m_data,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = ID_W + OFFSET_W;
  localparam logic [ID_W-1:0] ID_VAL = ID_W'(AUTOMATA_ID);
  localparam logic [LW-1:0]   FULL   = LW'(DEPTH);

  logic [OFFSET_W-1:0] sym_count, last_idx;
  logic                run_d;
  logic [DW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;

  logic push_req, pop, push_acc, drop;

  // The STE output lags its symbol by one cycle, so a report only counts
  // when the previous cycle actually consumed a symbol.
  assign push_req = report && run_d && !clear;
  assign pop      = m_valid && m_ready && !clear;
  assign push_acc = push_req && ((level != FULL) || pop);
  assign drop     = push_req && (level == FULL) && !pop;

  assign m_valid    = (level != '0);
  assign m_data     = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_count  <= '0;
      last_idx   <= '0;
      run_d      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      sym_count  <= '0;
      last_idx   <= '0;
      run_d      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (run) begin
        last_idx  <= sym_count;
        sym_count <= sym_count + 1'b1;
      end
      run_d <= run;
      // With a full FIFO and a pop, wr_ptr equals rd_ptr: the slot being freed takes the new tail.
      if (push_acc) begin
        mem[wr_ptr] <= {ID_VAL, last_idx};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push_acc) - LW'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_report_offset_collector.sv
// Directed bench for report_offset_collector, with a second instance using a 4-bit offset to exercise wrap.
// Expected records come from a queue scoreboard driven alongside the stimulus.
module tb_report_offset_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0, clear = 1'b0, report = 1'b0, m_ready = 1'b0;
  logic        m_valid, overflow;
  logic [47:0] m_data;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count;
  logic        w_valid, w_overflow;
  logic [19:0] w_data;
  logic [4:0]  w_level;
  logic [15:0] w_drop;

  always #5 clk = ~clk;

  report_offset_collector dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .report(report),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count));

  report_offset_collector #(.OFFSET_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .report(report),
    .m_valid(w_valid), .m_ready(m_ready), .m_data(w_data),
    .fifo_level(w_level), .overflow(w_overflow), .drop_count(w_drop));

  int tests = 0, fails = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [3:0]  q4[$];
  logic [31:0] m_sym = '0, m_last = '0;
  logic        m_rund = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_drop = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    q.delete(); q4.delete();
    m_sym = '0; m_last = '0; m_rund = 1'b0; m_ovf = 1'b0; m_drop = '0;
  endtask

  task automatic check_state();
    chk("m_valid", 64'(m_valid), 64'(q.size() != 0));
    chk("fifo_level", 64'(fifo_level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    if (q.size() != 0) chk("m_data", 64'(m_data), 64'({16'd62, q[0]}));
    chk("w_valid", 64'(w_valid), 64'(q4.size() != 0));
    chk("w_level", 64'(w_level), 64'(q4.size()));
    if (q4.size() != 0) chk("w_data", 64'(w_data), 64'({16'd62, q4[0]}));
  endtask

  // One clock cycle: check state, drive inputs, advance the model to the coming edge.
  task automatic cyc(input logic r, input logic rp, input logic rdy, input logic cl);
    @(negedge clk);
    check_state();
    run = r; report = rp; m_ready = rdy; clear = cl;
    if (cl) model_zero();
    else begin
      if (rdy && q.size() != 0) begin
        void'(q.pop_front());
        void'(q4.pop_front());
      end
      if (rp && m_rund) begin
        if (q.size() < 16) begin
          q.push_back(m_last);
          q4.push_back(m_last[3:0]);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 1'b1;
        end
      end
      if (r) begin
        m_last = m_sym;
        m_sym  = m_sym + 1;
      end
      m_rund = r;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic tagging: report the cycle after index 3
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("basic_valid", 64'(m_valid), 64'd1);
    chk("basic_rec", 64'(m_data), {16'd0, 16'd62, 32'd3});
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Unqualified reports are ignored
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("unq_valid", 64'(m_valid), 64'd0);
    chk("unq_drop", 64'(drop_count), 64'd0);

    // Backpressure: reports at indices 1,2,5,9
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= 10; i++)
      cyc(i < 10, (i == 2 || i == 3 || i == 6 || i == 10), 1'b0, 1'b0);
    after_edge();
    chk("bp_level", 64'(fifo_level), 64'd4);
    chk("bp_head", 64'(m_data), {16'd0, 16'd62, 32'd1});
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: 18 reports into a 16-deep FIFO
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 18; i++) cyc(i < 18, i >= 1, 1'b0, 1'b0);
    after_edge();
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_count), 64'd2);
    // Full with simultaneous push and pop: no drop
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("full_pp_level", 64'(fifo_level), 64'd16);
    chk("full_pp_drop", 64'(drop_count), 64'd2);
    for (int i = 0; i < 18; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Wrap with the 4-bit offset instance
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 18; i++) cyc(i < 18, i == 18, 1'b0, 1'b0);
    after_edge();
    chk("wrap_rec", 64'(w_data), {44'd0, 16'd62, 4'd1});
    chk("wrap_full", 64'(m_data), {16'd0, 16'd62, 32'd17});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // clear with 3 queued records and overflow set; coincident run/report discarded
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 18; i++) cyc(i < 18, i >= 1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    after_edge();
    chk("clr_valid", 64'(m_valid), 64'd0);
    chk("clr_level", 64'(fifo_level), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_count), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("clr_next_sym", 64'(m_data), {16'd0, 16'd62, 32'd0});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with records queued and overflow set
    for (int i = 0; i <= 18; i++) cyc(i < 18, i >= 1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(m_valid), 64'd0);
    chk("arst_data", 64'(m_data), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_drop", 64'(drop_count), 64'd0);
    chk("arst_w_valid", 64'(w_valid), 64'd0);
    model_zero();
    run = 1'b0; report = 1'b0; m_ready = 1'b0; clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("arst_next_sym", 64'(m_data), {16'd0, 16'd62, 32'd0});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
